// File: rtl/serial_link_power_seq_if.sv
// Control/status bundle between a serial link's power sequencer and the
// clock gate, link reset and AXI isolation cells it drives.
interface serial_link_power_seq_if;
    logic       en_req_i;
    logic [1:0] isolated_i;
    logic       err_clr_i;
    logic [1:0] isolate_o;
    logic       clk_ena_o;
    logic       reset_no;
    logic       up_o;
    logic       busy_o;
    logic       err_o;

    // The master requests power state changes and reports isolation status.
    modport master (
        output en_req_i, isolated_i, err_clr_i,
        input  isolate_o, clk_ena_o, reset_no, up_o, busy_o, err_o
    );

    modport slave (
        input  en_req_i, isolated_i, err_clr_i,
        output isolate_o, clk_ena_o, reset_no, up_o, busy_o, err_o
    );
endinterface

// File: rtl/serial_link_power_seq.sv
// Power sequencer for a serial link: clock enable -> reset release -> de-isolate
// on the way up, and the reverse on the way down, with a sticky handshake timeout.
module serial_link_power_seq #(
    parameter int unsigned ClkCycles     = 4,
    parameter int unsigned RstCycles     = 8,
    parameter int unsigned TimeoutCycles = 1024
) (
    input  logic                    clk_i,
    input  logic                    rst_ni,
    serial_link_power_seq_if.slave  link
);

    localparam int unsigned MaxAb     = (ClkCycles > RstCycles) ? ClkCycles : RstCycles;
    localparam int unsigned MaxCycles = (MaxAb > TimeoutCycles) ? MaxAb : TimeoutCycles;
    localparam int unsigned CntW      = $clog2(MaxCycles) + 1;

    localparam logic [CntW-1:0] ClkLoad = CntW'(ClkCycles - 1);
    localparam logic [CntW-1:0] RstLoad = CntW'(RstCycles - 1);
    localparam logic [CntW-1:0] ToLoad  = CntW'(TimeoutCycles - 1);

    typedef enum logic [2:0] {
        OFF, CLK_EN, RST_REL, DEISO, ON, ISO, RST_ASRT, CLK_DIS
    } state_e;

    state_e          state_q, state_d;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic [1:0]      isolate_q, isolate_d;
    logic            clk_ena_q, clk_ena_d;
    logic            reset_n_q, reset_n_d;
    logic            up_q, up_d;
    logic            busy_q, busy_d;
    logic            err_q, err_d;
    logic            cnt_zero;
    logic            timeout;

    assign cnt_zero = (cnt_q == '0);

    // Every output is a flop loaded from the decode of the next state, so the
    // clock gate and link reset never see combinational glitches.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q   <= OFF;
            cnt_q     <= '0;
            isolate_q <= 2'b11;
            clk_ena_q <= 1'b0;
            reset_n_q <= 1'b0;
            up_q      <= 1'b0;
            busy_q    <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            isolate_q <= isolate_d;
            clk_ena_q <= clk_ena_d;
            reset_n_q <= reset_n_d;
            up_q      <= up_d;
            busy_q    <= busy_d;
            err_q     <= err_d;
        end
    end

    always_comb begin
        state_d = state_q;
        timeout = 1'b0;
        case (state_q)
            OFF:      if (link.en_req_i && !err_q) state_d = CLK_EN;
            CLK_EN:   if (cnt_zero) state_d = RST_REL;
            RST_REL:  if (cnt_zero) state_d = link.en_req_i ? DEISO : RST_ASRT;
            DEISO: begin
                // A completed handshake beats both an abort and a timeout.
                if (link.isolated_i == 2'b00) begin
                    state_d = ON;
                end else if (!link.en_req_i) begin
                    state_d = ISO;
                end else if (cnt_zero) begin
                    timeout = 1'b1;
                    state_d = ISO;
                end
            end
            ON:       if (!link.en_req_i) state_d = ISO;
            ISO: begin
                if (link.isolated_i == 2'b11) begin
                    state_d = RST_ASRT;
                end else if (cnt_zero) begin
                    timeout = 1'b1;
                    state_d = RST_ASRT;
                end
            end
            RST_ASRT: if (cnt_zero) state_d = CLK_DIS;
            CLK_DIS:  if (cnt_zero) state_d = OFF;
            default:  state_d = OFF;
        endcase
    end

    always_comb begin
        isolate_d = 2'b11;
        clk_ena_d = 1'b0;
        reset_n_d = 1'b0;
        up_d      = (state_d == ON);
        busy_d    = (state_d != OFF) && (state_d != ON);
        case (state_d)
            CLK_EN:   clk_ena_d = 1'b1;
            RST_REL, ISO: begin
                clk_ena_d = 1'b1;
                reset_n_d = 1'b1;
            end
            DEISO, ON: begin
                isolate_d = 2'b00;
                clk_ena_d = 1'b1;
                reset_n_d = 1'b1;
            end
            RST_ASRT: clk_ena_d = 1'b1;
            default:  ;
        endcase

        // Load on entry so each state is held for exactly its load + 1 cycles.
        if (state_d != state_q) begin
            case (state_d)
                CLK_EN, CLK_DIS:  cnt_d = ClkLoad;
                RST_REL, RST_ASRT: cnt_d = RstLoad;
                DEISO, ISO:       cnt_d = ToLoad;
                default:          cnt_d = '0;
            endcase
        end else if (!cnt_zero) begin
            cnt_d = cnt_q - CntW'(1);
        end else begin
            cnt_d = cnt_q;
        end

        if (timeout) begin
            err_d = 1'b1;
        end else if (link.err_clr_i) begin
            err_d = 1'b0;
        end else begin
            err_d = err_q;
        end
    end

    assign link.isolate_o = isolate_q;
    assign link.clk_ena_o = clk_ena_q;
    assign link.reset_no  = reset_n_q;
    assign link.up_o      = up_q;
    assign link.busy_o    = busy_q;
    assign link.err_o     = err_q;

endmodule

// File: tb/tb_serial_link_power_seq.sv
// Scoreboard bench: each scenario queues timed output snapshots when it drives
// a request; a negedge monitor pops and compares them as the cycle arrives.
module tb_serial_link_power_seq;

    typedef struct {
        int         cyc;
        logic [1:0] iso;
        logic       ce;
        logic       rn;
        logic       up;
        logic       busy;
        logic       err;
        string      tag;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst_n = 1'b1;
    logic       stuck = 1'b0;
    logic       abort_watch = 1'b0;
    logic       saw_deiso = 1'b0;
    logic [1:0] iso_d1 = 2'b11;
    int         cyc = 0;
    int         checks = 0;
    int         failures = 0;
    int         k;
    exp_t       exp_q[$];

    serial_link_power_seq_if link_if ();

    serial_link_power_seq #(
        .ClkCycles    (4),
        .RstCycles    (8),
        .TimeoutCycles(16)
    ) dut (
        .clk_i (clk),
        .rst_ni(rst_n),
        .link  (link_if)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Isolation cells answer two edges after the request changes, unless stuck.
    always @(negedge clk) begin
        if (stuck) link_if.isolated_i <= 2'b11;
        else       link_if.isolated_i <= iso_d1;
        iso_d1 <= link_if.isolate_o;
    end

    always @(negedge clk) begin
        if (abort_watch && link_if.isolate_o != 2'b11) saw_deiso <= 1'b1;
    end

    task automatic check_output(input string tag, input logic [31:0] actual,
                                input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s actual=%0h expected=%0h", tag, actual, expected);
        end
    endtask

    task automatic apply_stimulus(input logic en, input logic clr);
        @(negedge clk);
        link_if.en_req_i  = en;
        link_if.err_clr_i = clr;
    endtask

    task automatic wait_until(input int c);
        while (cyc < c) @(negedge clk);
    endtask

    task automatic push_exp(input int c, input logic [1:0] iso, input logic ce,
                            input logic rn, input logic up, input logic busy,
                            input logic err, input string tag);
        exp_t e;
        e.cyc = c; e.iso = iso; e.ce = ce; e.rn = rn;
        e.up = up; e.busy = busy; e.err = err; e.tag = tag;
        exp_q.push_back(e);
    endtask

    always @(negedge clk) begin
        while (exp_q.size() > 0 && exp_q[0].cyc <= cyc) begin
            exp_t e;
            e = exp_q.pop_front();
            if (e.cyc != cyc) check_output({e.tag, ".late"}, cyc, e.cyc);
            check_output({e.tag, ".isolate"}, link_if.isolate_o, e.iso);
            check_output({e.tag, ".clk_ena"}, link_if.clk_ena_o, e.ce);
            check_output({e.tag, ".reset_n"}, link_if.reset_no, e.rn);
            check_output({e.tag, ".up"},      link_if.up_o, e.up);
            check_output({e.tag, ".busy"},    link_if.busy_o, e.busy);
            check_output({e.tag, ".err"},     link_if.err_o, e.err);
        end
    end

    initial begin
        link_if.en_req_i   = 1'b0;
        link_if.err_clr_i  = 1'b0;
        link_if.isolated_i = 2'b11;
        #1 rst_n = 1'b0;
        #2;
        check_output("rst.isolate", link_if.isolate_o, 2'b11);
        check_output("rst.clk_ena", link_if.clk_ena_o, 1'b0);
        check_output("rst.reset_n", link_if.reset_no, 1'b0);
        check_output("rst.busy",    link_if.busy_o, 1'b0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        // Power-up from OFF.
        apply_stimulus(1'b1, 1'b0);
        k = cyc + 1;
        push_exp(k,      2'b11, 1, 0, 0, 1, 0, "pu_clken");
        push_exp(k + 3,  2'b11, 1, 0, 0, 1, 0, "pu_clken_last");
        push_exp(k + 4,  2'b11, 1, 1, 0, 1, 0, "pu_rstrel");
        push_exp(k + 11, 2'b11, 1, 1, 0, 1, 0, "pu_rstrel_last");
        push_exp(k + 12, 2'b00, 1, 1, 0, 1, 0, "pu_deiso");
        push_exp(k + 13, 2'b00, 1, 1, 0, 1, 0, "pu_deiso_wait");
        push_exp(k + 14, 2'b00, 1, 1, 1, 0, 0, "pu_on");
        wait_until(k + 16);

        // Power-down from ON.
        apply_stimulus(1'b0, 1'b0);
        k = cyc + 1;
        push_exp(k,      2'b11, 1, 1, 0, 1, 0, "pd_iso");
        push_exp(k + 1,  2'b11, 1, 1, 0, 1, 0, "pd_iso_wait");
        push_exp(k + 2,  2'b11, 1, 0, 0, 1, 0, "pd_rstasrt");
        push_exp(k + 9,  2'b11, 1, 0, 0, 1, 0, "pd_rstasrt_last");
        push_exp(k + 10, 2'b11, 0, 0, 0, 1, 0, "pd_clkdis");
        push_exp(k + 13, 2'b11, 0, 0, 0, 1, 0, "pd_clkdis_last");
        push_exp(k + 14, 2'b11, 0, 0, 0, 0, 0, "pd_off");
        wait_until(k + 16);

        // DEISO timeout with isolation stuck, clear coincident with the timeout.
        stuck = 1'b1;
        apply_stimulus(1'b1, 1'b0);
        k = cyc + 1;
        push_exp(k,      2'b11, 1, 0, 0, 1, 0, "to_clken");
        push_exp(k + 12, 2'b00, 1, 1, 0, 1, 0, "to_deiso");
        push_exp(k + 27, 2'b00, 1, 1, 0, 1, 0, "to_deiso_last");
        push_exp(k + 28, 2'b11, 1, 1, 0, 1, 1, "to_iso_err");
        push_exp(k + 29, 2'b11, 1, 0, 0, 1, 1, "to_rstasrt");
        push_exp(k + 37, 2'b11, 0, 0, 0, 1, 1, "to_clkdis");
        push_exp(k + 41, 2'b11, 0, 0, 0, 0, 1, "to_off");
        push_exp(k + 45, 2'b11, 0, 0, 0, 0, 1, "to_off_hold");
        push_exp(k + 46, 2'b11, 0, 0, 0, 0, 0, "to_cleared");
        push_exp(k + 47, 2'b11, 1, 0, 0, 1, 0, "to_restart");
        push_exp(k + 61, 2'b00, 1, 1, 1, 0, 0, "to_on");
        wait_until(k + 26);
        apply_stimulus(1'b1, 1'b1);
        apply_stimulus(1'b1, 1'b0);
        wait_until(k + 44);
        apply_stimulus(1'b1, 1'b1);
        stuck = 1'b0;
        apply_stimulus(1'b1, 1'b0);
        wait_until(k + 63);

        // Asynchronous reset while ON, checked before the next rising edge.
        #2 rst_n = 1'b0;
        #1;
        check_output("arst.isolate", link_if.isolate_o, 2'b11);
        check_output("arst.clk_ena", link_if.clk_ena_o, 1'b0);
        check_output("arst.reset_n", link_if.reset_no, 1'b0);
        check_output("arst.up",      link_if.up_o, 1'b0);
        check_output("arst.busy",    link_if.busy_o, 1'b0);
        check_output("arst.err",     link_if.err_o, 1'b0);

        // Release with en_req held, then abort during RST_REL.
        @(negedge clk);
        rst_n = 1'b1;
        abort_watch = 1'b1;
        k = cyc + 1;
        push_exp(k,      2'b11, 1, 0, 0, 1, 0, "ab_clken");
        push_exp(k + 4,  2'b11, 1, 1, 0, 1, 0, "ab_rstrel");
        push_exp(k + 11, 2'b11, 1, 1, 0, 1, 0, "ab_rstrel_last");
        push_exp(k + 12, 2'b11, 1, 0, 0, 1, 0, "ab_rstasrt");
        push_exp(k + 20, 2'b11, 0, 0, 0, 1, 0, "ab_clkdis");
        push_exp(k + 24, 2'b11, 0, 0, 0, 0, 0, "ab_off");
        wait_until(k + 5);
        apply_stimulus(1'b0, 1'b0);
        wait_until(k + 26);
        abort_watch = 1'b0;

        check_output("abort_iso_held", saw_deiso, 1'b0);
        check_output("queue_drained", exp_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
